// File: rtl/systolic_skew_feeder.sv
// Edge feeder for an N x N systolic MAC array: buffers A and B from a load
// stream, clears the array, then drives the west/north edges with diagonal skew.
module systolic_skew_feeder #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic [N*DW-1:0] a_edge,
  output logic [N*DW-1:0] b_edge,
  output logic            edge_valid,
  output logic            array_clr,
  output logic            busy,
  output logic            done
);

  localparam int unsigned Words = 2 * N * N;
  localparam int unsigned LdW   = $clog2(Words);
  localparam int unsigned TW    = $clog2(3 * N - 2);
  localparam int          NI    = int'(N);

  localparam logic [LdW-1:0] LdLast = LdW'(Words - 1);
  localparam logic [TW-1:0]  TLast  = TW'(3 * N - 3);

  typedef enum logic [2:0] {StIdle, StLoad, StClear, StStream, StFlush} state_e;

  state_e         state_q, state_d;
  logic [LdW-1:0] ld_cnt_q, ld_cnt_d;
  logic [TW-1:0]  t_q, t_d;
  logic           accept;

  // A occupies words 0..N*N-1 row-major, B follows at N*N.. row-major
  logic [DW-1:0]  mem_q [Words];

  logic            in_ready_q, in_ready_d;
  logic [N*DW-1:0] a_edge_q, a_edge_d;
  logic [N*DW-1:0] b_edge_q, b_edge_d;
  logic            edge_valid_q, edge_valid_d;
  logic            array_clr_q, array_clr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  assign accept = in_valid & in_ready_q;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ld_cnt_q <= '0;
      t_q      <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      t_q      <= t_d;
    end
  end

  // Operand buffer write; contents need no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[ld_cnt_q] <= in_data;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    t_d      = '0;
    if (accept) begin
      ld_cnt_d = (ld_cnt_q == LdLast) ? '0 : ld_cnt_q + 1'b1;
    end
    // t_d is the skew step of the coming cycle; CLEAR leaves it at 0
    if (state_q == StStream) begin
      t_d = t_q + 1'b1;
    end
    unique case (state_q)
      StIdle:   if (accept) state_d = StLoad;
      StLoad:   if (accept && ld_cnt_q == LdLast) state_d = StClear;
      StClear:  state_d = StStream;
      StStream: if (t_q == TLast) state_d = StFlush;
      StFlush:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output next values, derived from the coming state so outputs can be registered
  always_comb begin
    in_ready_d   = (state_d == StIdle) || (state_d == StLoad);
    busy_d       = (state_d != StIdle);
    array_clr_d  = (state_d == StClear);
    edge_valid_d = (state_d == StStream);
    done_d       = (state_d == StFlush);
    a_edge_d     = '0;
    b_edge_d     = '0;
    if (state_d == StStream) begin
      // Lane i carries A[i][t-i] and B[t-i][i] while the inner index is in range
      for (int i = 0; i < NI; i++) begin
        if (int'(t_d) >= i && int'(t_d) < i + NI) begin
          a_edge_d[i*DW +: DW] = mem_q[LdW'(i * NI + int'(t_d) - i)];
          b_edge_d[i*DW +: DW] = mem_q[LdW'(NI * NI + (int'(t_d) - i) * NI + i)];
        end
      end
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q   <= 1'b0;
      a_edge_q     <= '0;
      b_edge_q     <= '0;
      edge_valid_q <= 1'b0;
      array_clr_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      in_ready_q   <= in_ready_d;
      a_edge_q     <= a_edge_d;
      b_edge_q     <= b_edge_d;
      edge_valid_q <= edge_valid_d;
      array_clr_q  <= array_clr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign a_edge     = a_edge_q;
  assign b_edge     = b_edge_q;
  assign edge_valid = edge_valid_q;
  assign array_clr  = array_clr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: one N=2 and one N=4 instance, a job-timeline
// model, and a behavioural systolic array hung on the edges to check C = A x B.
module tb_systolic_skew_feeder;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    iv, ir, ev, clr, bsy, dn;
  logic [DW-1:0] id [2];
  logic [63:0]   ae0, be0;
  logic [127:0]  ae1, be1;

  systolic_skew_feeder #(.N(2), .DW(DW)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .a_edge(ae0), .b_edge(be0), .edge_valid(ev[0]), .array_clr(clr[0]),
    .busy(bsy[0]), .done(dn[0])
  );

  systolic_skew_feeder #(.N(4), .DW(DW)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .a_edge(ae1), .b_edge(be1), .edge_valid(ev[1]), .array_clr(clr[1]),
    .busy(bsy[1]), .done(dn[1])
  );

  int n_pass = 0;
  int n_chk  = 0;
  bit chk_en = 1'b0;

  // Job timeline model: k = cycles since the last load word (1 = clear,
  // 2..3N-1 = stream step k-2, 3N = done), -1 while idle or loading
  int          m_cnt [2];
  int          m_k   [2];
  bit          m_rdy [2];
  logic [31:0] ma  [2][4][4];
  logic [31:0] mb  [2][4][4];
  // Behavioural PE array fed by the DUT edges
  logic [31:0] pa  [2][4][4];
  logic [31:0] pb  [2][4][4];
  logic [31:0] acc [2][4][4];
  // Words the stimulus will send for the next job
  logic [31:0] jw  [2][32];

  function automatic int nof(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic logic [127:0] a_of(input int d);
    return (d == 0) ? {64'b0, ae0} : ae1;
  endfunction

  function automatic logic [127:0] b_of(input int d);
    return (d == 0) ? {64'b0, be0} : be1;
  endfunction

  function automatic logic [31:0] c_ref(input int d, input int i, input int j);
    int n;
    logic [31:0] s;
    n = nof(d);
    s = '0;
    for (int k = 0; k < n; k++) s = s + jw[d][i*n+k] * jw[d][n*n+k*n+j];
    return s;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Model and PE array advance on every rising edge
  initial begin
    int n, w;
    logic [127:0] ae_v, be_v;
    logic [31:0] ain, bin;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        n = nof(d);
        ae_v = a_of(d);
        be_v = b_of(d);
        if (clr[d] === 1'b1) begin
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
              pa[d][i][j] = '0; pb[d][i][j] = '0; acc[d][i][j] = '0;
            end
        end else begin
          for (int i = n - 1; i >= 0; i--)
            for (int j = n - 1; j >= 0; j--) begin
              if (j == 0) ain = ae_v[i*32 +: 32];
              else        ain = pa[d][i][j-1];
              if (i == 0) bin = be_v[j*32 +: 32];
              else        bin = pb[d][i-1][j];
              acc[d][i][j] = acc[d][i][j] + ain * bin;
              pa[d][i][j] = ain;
              pb[d][i][j] = bin;
            end
        end
        if (rst) begin
          m_cnt[d] = 0; m_k[d] = -1; m_rdy[d] = 1'b0;
        end else if (m_k[d] >= 1) begin
          if (m_k[d] == 3 * n) begin
            m_k[d] = -1; m_rdy[d] = 1'b1;
          end else begin
            m_k[d] = m_k[d] + 1;
          end
        end else begin
          m_rdy[d] = 1'b1;
          if (iv[d] && m_rdy[d]) begin
            w = m_cnt[d];
            if (w < n * n) ma[d][w/n][w%n] = id[d];
            else           mb[d][(w-n*n)/n][(w-n*n)%n] = id[d];
            m_cnt[d] = w + 1;
            if (m_cnt[d] == 2 * n * n) begin
              m_cnt[d] = 0; m_k[d] = 1; m_rdy[d] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Compare every output of both instances against the model on falling edges
  initial begin
    int n, k, t, kk;
    logic [127:0] ea, eb;
    string p;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int d = 0; d < 2; d++) begin
          n = nof(d);
          k = m_k[d];
          p = $sformatf("N%0d", n);
          ea = '0;
          eb = '0;
          if (k >= 2 && k <= 3 * n - 1) begin
            t = k - 2;
            for (int i = 0; i < n; i++) begin
              kk = t - i;
              if (kk >= 0 && kk < n) begin
                ea[i*32 +: 32] = ma[d][i][kk];
                eb[i*32 +: 32] = mb[d][kk][i];
              end
            end
          end
          check({p, " in_ready"},   128'(ir[d]),  128'(m_rdy[d]));
          check({p, " busy"},       128'(bsy[d]), 128'((k >= 1) || (m_cnt[d] > 0)));
          check({p, " array_clr"},  128'(clr[d]), 128'(k == 1));
          check({p, " edge_valid"}, 128'(ev[d]),  128'(k >= 2 && k <= 3 * n - 1));
          check({p, " done"},       128'(dn[d]),  128'(k == 3 * n));
          check({p, " a_edge"},     a_of(d), ea);
          check({p, " b_edge"},     b_of(d), eb);
        end
      end
    end
  end

  // Present jw[d] as a load; returns at the falling edge after the last acceptance
  task automatic send_job(input int d, input bit gaps);
    int n, w, guard, hs;
    n = nof(d);
    w = 0; guard = 0; hs = 0;
    while (w < 2 * n * n && guard < 2000) begin
      @(negedge clk);
      iv[d] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      id[d] = iv[d] ? jw[d][w] : $urandom;
      if (iv[d] && ir[d]) hs++;
      if (iv[d] && m_rdy[d]) w++;
      guard++;
    end
    @(negedge clk);
    iv[d] = 1'b0;
    id[d] = '0;
    check($sformatf("N%0d words consumed", n), 128'(hs), 128'(2 * n * n));
  endtask

  // Wait for done (optionally poking in_valid meanwhile), then check C
  task automatic wait_done(input int d, input bit noise);
    int g, n;
    bit seen;
    n = nof(d);
    g = 0; seen = 1'b0;
    while (g < 200 && !seen) begin
      @(negedge clk);
      if (dn[d]) seen = 1'b1;
      else if (noise) begin
        iv[d] = 1'($urandom_range(0, 1));
        id[d] = $urandom;
      end
      g++;
    end
    iv[d] = 1'b0;
    check($sformatf("N%0d done seen", n), 128'(seen), 128'(1));
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        check($sformatf("N%0d C[%0d][%0d]", n, i, j), 128'(acc[d][i][j]), 128'(c_ref(d, i, j)));
  endtask

  initial begin
    #400000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] la [4];
    logic [63:0] lb [4];
    int g;
    la[0] = 64'h00000000_00000001; lb[0] = 64'h00000000_00000005;
    la[1] = 64'h00000003_00000002; lb[1] = 64'h00000006_00000007;
    la[2] = 64'h00000004_00000000; lb[2] = 64'h00000008_00000000;
    la[3] = 64'h00000000_00000000; lb[3] = 64'h00000000_00000000;

    rst = 1'b1;
    iv = '0;
    id[0] = '0;
    id[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset ctrl", 128'({ir, ev, clr, bsy, dn}), 128'(0));
    check("reset edges N2", 128'({ae0, be0}), 128'(0));
    check("reset edges N4", ae1 | be1, 128'(0));
    rst = 1'b0;

    // N=2 reference job with literal skew table and literal C
    for (int w = 0; w < 8; w++) jw[0][w] = 32'(w + 1);
    send_job(0, 1'b0);
    check("N2 clear pulse", 128'(clr[0]), 128'(1));
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check($sformatf("N2 lit a t%0d", t), 128'(ae0), 128'(la[t]));
      check($sformatf("N2 lit b t%0d", t), 128'(be0), 128'(lb[t]));
    end
    @(negedge clk);
    check("N2 lit done", 128'(dn[0]), 128'(1));
    check("N2 lit C00", 128'(acc[0][0][0]), 128'(19));
    check("N2 lit C01", 128'(acc[0][0][1]), 128'(22));
    check("N2 lit C10", 128'(acc[0][1][0]), 128'(43));
    check("N2 lit C11", 128'(acc[0][1][1]), 128'(50));

    // N=4 job with random in_valid gaps
    for (int w = 0; w < 32; w++) jw[1][w] = 32'($urandom_range(0, 999));
    send_job(1, 1'b1);
    wait_done(1, 1'b0);

    // N=2 job with in_valid noise while streaming
    for (int w = 0; w < 8; w++) jw[0][w] = 32'(3 * w + 2);
    send_job(0, 1'b0);
    wait_done(0, 1'b1);

    // Reset during stream step 1, then a fresh job
    for (int w = 0; w < 8; w++) jw[0][w] = 32'(w + 11);
    send_job(0, 1'b0);
    g = 0;
    while (m_k[0] != 3 && g < 20) begin
      @(negedge clk);
      g++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("N2 rst mid ctrl", 128'({ir[0], ev[0], clr[0], bsy[0], dn[0]}), 128'(0));
    check("N2 rst mid edges", 128'({ae0, be0}), 128'(0));
    rst = 1'b0;
    for (int w = 0; w < 8; w++) jw[0][w] = 32'(9 - w);
    send_job(0, 1'b0);
    wait_done(0, 1'b0);

    // Back-to-back jobs: second load starts in the idle cycle after done
    for (int w = 0; w < 8; w++) jw[0][w] = 32'(w * w + 1);
    send_job(0, 1'b0);
    wait_done(0, 1'b0);
    for (int w = 0; w < 8; w++) jw[0][w] = 32'((w % 3) + 20);
    send_job(0, 1'b0);
    wait_done(0, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
